// File: rtl/sample_feeder_pkg.sv
// Shared types and helpers for the sample stream feeder.
//   feeder_state_t : IDLE / STREAM / DONE controller states
//   ceil_div       : integer ceiling division for elaboration-time sizing
package sample_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/sample_stream_feeder_if.sv
// Bundle of the feeder's data, control and status signals.
//   master : the feeder itself (drives the beat stream and status)
//   slave  : the environment (sample store, controller, downstream sink)
// Control: samples, start, abort, num_passes, out_ready
// Stream : out_data, out_mask, out_valid, out_last, out_final
// Status : beat_idx, pass_idx, busy, done
interface sample_stream_feeder_if
  import sample_feeder_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int SAMPLE_SIZE = 4,
  parameter int DATA_SIZE   = 4,
  parameter int LANES       = 2,
  parameter int PASS_W      = 4
);
  localparam int W         = SAMPLE_SIZE * DATA_SIZE;
  localparam int NUM_BEATS = ceil_div(NUM_SAMPLES, LANES);
  localparam int BEAT_W    = $clog2(NUM_BEATS) + 1;

  logic [NUM_SAMPLES*W-1:0] samples;
  logic                     start;
  logic                     abort;
  logic [PASS_W-1:0]        num_passes;
  logic [LANES*W-1:0]       out_data;
  logic [LANES-1:0]         out_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     out_final;
  logic [BEAT_W-1:0]        beat_idx;
  logic [PASS_W-1:0]        pass_idx;
  logic                     busy;
  logic                     done;

  modport master (
    input  samples, start, abort, num_passes, out_ready,
    output out_data, out_mask, out_valid, out_last, out_final,
           beat_idx, pass_idx, busy, done
  );

  modport slave (
    output samples, start, abort, num_passes, out_ready,
    input  out_data, out_mask, out_valid, out_last, out_final,
           beat_idx, pass_idx, busy, done
  );

endinterface

// File: rtl/sample_stream_fsm.sv
// Stream controller: IDLE/STREAM/DONE state machine plus the beat and pass
// counters it steps.
//   clk, rst_n    : clock, async active-low reset
//   start_i       : request a new stream (honoured only in IDLE)
//   abort_i       : terminate the running stream
//   handshake_i   : current beat transferred this cycle
//   lastBeat_i    : current beat is the last beat of a pass
//   finalPass_i   : current pass is the last one (never with endless passes)
//   state_o       : current controller state
//   startAccept_o : start accepted this cycle (latch pass count, clear counters)
//   beatIdx_o     : beat index within the pass
//   passIdx_o     : pass index
module sample_stream_fsm
  import sample_feeder_pkg::*;
#(
  parameter int BEAT_W = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              handshake_i,
  input  logic              lastBeat_i,
  input  logic              finalPass_i,
  output feeder_state_t     state_o,
  output logic              startAccept_o,
  output logic [BEAT_W-1:0] beatIdx_o,
  output logic [PASS_W-1:0] passIdx_o
);

  feeder_state_t     state_q, state_d;
  logic [BEAT_W-1:0] beatIdx_q;
  logic [PASS_W-1:0] passIdx_q;
  logic              beatInc, beatClr, passInc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort outranks a simultaneous handshake: the beat still counts as sent,
  // but the stream stops there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i && !abort_i) state_d = STREAM;
      STREAM: begin
        if (abort_i)                                        state_d = IDLE;
        else if (handshake_i && lastBeat_i && finalPass_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A last-beat handshake with passes remaining rewinds the beat counter and
  // advances the pass counter in the same cycle, so there is no bubble.
  always_comb begin
    startAccept_o = (state_q == IDLE) && start_i && !abort_i;
    beatInc       = 1'b0;
    passInc       = 1'b0;
    if (state_q == STREAM && !abort_i && handshake_i) begin
      if (!lastBeat_i)       beatInc = 1'b1;
      else if (!finalPass_i) passInc = 1'b1;
    end
    beatClr = startAccept_o || passInc;
  end

  // The pass counter wraps naturally in endless mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beatIdx_q <= '0;
      passIdx_q <= '0;
    end else begin
      if (beatClr)      beatIdx_q <= '0;
      else if (beatInc) beatIdx_q <= beatIdx_q + 1'b1;
      if (startAccept_o) passIdx_q <= '0;
      else if (passInc)  passIdx_q <= passIdx_q + 1'b1;
    end
  end

  assign state_o   = state_q;
  assign beatIdx_o = beatIdx_q;
  assign passIdx_o = passIdx_q;

endmodule

// File: rtl/sample_stream_feeder.sv
// Streams a flat bus of NUM_SAMPLES samples as beats of LANES samples with a
// valid/ready handshake, optionally repeating for several passes.
//   clk, rst_n : clock, async active-low reset
//   bus        : sample_stream_feeder_if master port (samples/control in,
//                beat stream and status out)
module sample_stream_feeder
  import sample_feeder_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int SAMPLE_SIZE = 4,
  parameter int DATA_SIZE   = 4,
  parameter int LANES       = 2,
  parameter int PASS_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sample_stream_feeder_if.master bus
);

  localparam int W         = SAMPLE_SIZE * DATA_SIZE;
  localparam int NUM_BEATS = ceil_div(NUM_SAMPLES, LANES);
  localparam int BEAT_W    = $clog2(NUM_BEATS) + 1;
  localparam int PAD_W     = NUM_BEATS * LANES * W;

  feeder_state_t     state;
  logic              startAccept;
  logic [BEAT_W-1:0] beatIdx;
  logic [PASS_W-1:0] passIdx;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              streaming, handshake, lastBeat, finalPass;
  logic [PAD_W-1:0]  paddedSamples;
  wire  [LANES*W-1:0] laneData;
  wire  [LANES-1:0]   laneMask;

  assign streaming = (state == STREAM);
  assign handshake = streaming && bus.out_ready;
  assign lastBeat  = (beatIdx == BEAT_W'(NUM_BEATS - 1));
  // A pass count of zero means "repeat until abort", so it is never final.
  assign finalPass = (passes_q != '0) &&
                     ((PASS_W+1)'(passIdx) + (PASS_W+1)'(1) == (PASS_W+1)'(passes_q));

  always_comb begin
    passes_d = passes_q;
    if (startAccept) passes_d = bus.num_passes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) passes_q <= '0;
    else        passes_q <= passes_d;
  end

  sample_stream_fsm #(
    .BEAT_W(BEAT_W),
    .PASS_W(PASS_W)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (bus.start),
    .abort_i      (bus.abort),
    .handshake_i  (handshake),
    .lastBeat_i   (lastBeat),
    .finalPass_i  (finalPass),
    .state_o      (state),
    .startAccept_o(startAccept),
    .beatIdx_o    (beatIdx),
    .passIdx_o    (passIdx)
  );

  // Zero-extending the bus to a whole number of beats keeps every lane
  // select in range; lanes past the end read zeros.
  assign paddedSamples = PAD_W'(bus.samples);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W-1:0] data;
    logic         real_sample;

    always_comb begin
      data        = '0;
      real_sample = 1'b0;
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beatIdx == BEAT_W'(b)) begin
          data        = paddedSamples[(b*LANES+k)*W +: W];
          real_sample = (b * LANES + k) < NUM_SAMPLES;
        end
      end
    end

    assign laneData[k*W +: W] = data;
    assign laneMask[k]        = real_sample;
  end

  assign bus.out_data  = laneData;
  assign bus.out_mask  = laneMask;
  assign bus.out_valid = streaming;
  assign bus.out_last  = streaming && lastBeat;
  assign bus.out_final = streaming && lastBeat && finalPass;
  assign bus.beat_idx  = beatIdx;
  assign bus.pass_idx  = passIdx;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule
